alu64_flag_unit: RTL and testbench

- 64-bit integer execution unit for the single-cycle CPU.
- Combines three parts:
  - a combinational 64-bit ALU with ARM-style N/Z/V/C flags;
  - a 64-bit two-operand adder that the ALU uses for add and subtract;
  - two enabled registers, a 64-bit result register and a 4-bit flag register.
- Sits between the register-file read ports / immediate mux and the data-memory / writeback path.
- The registered flags feed conditional-branch decode (B.LT uses N != V). The combinational zero flag feeds CBZ.

---
 rtl/alu64_flag_unit_pkg.sv | 19 +
 rtl/alu64_flag_unit_add64.sv | 19 +
 rtl/alu64_flag_unit.sv | 92 +++++++++
 tb/tb_alu64_flag_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu64_flag_unit_pkg.sv
// Shared constants for the 64-bit execution unit: ALU opcodes and flag-register bit positions.
package alu64_flag_unit_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_PASS_B = 3'b000;
    localparam alu_op_t ALU_ADD    = 3'b010;
    localparam alu_op_t ALU_SUB    = 3'b011;
    localparam alu_op_t ALU_AND    = 3'b100;
    localparam alu_op_t ALU_OR     = 3'b101;
    localparam alu_op_t ALU_XOR    = 3'b110;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/alu64_flag_unit_add64.sv
// Two-operand adder with carry-in.
// Exposes the carry into the MSB so callers can derive signed overflow.
module alu64_flag_unit_add64 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c63
);

    // Split at the MSB so the carry into the top bit is visible.
    assign {c63, sum[WIDTH-2:0]} = {1'b0, a[WIDTH-2:0]} + {1'b0, b[WIDTH-2:0]}
                                 + {{(WIDTH-1){1'b0}}, cin};
    assign {cout, sum[WIDTH-1]}  = {1'b0, a[WIDTH-1]} + {1'b0, b[WIDTH-1]} + {1'b0, c63};

endmodule

// File: rtl/alu64_flag_unit.sv
// Combinational 64-bit ALU with N/Z/V/C flags, plus enabled result and flag registers
// with synchronous active-high reset.
module alu64_flag_unit
    import alu64_flag_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           cntrl,
    input  logic                 set_flags,
    input  logic                 result_en,
    output logic [WIDTH-1:0]     result,
    output logic                 negative,
    output logic                 zero,
    output logic                 overflow,
    output logic                 carry_out,
    output logic [NUM_FLAGS-1:0] flags_q,
    output logic [WIDTH-1:0]     result_q
);

    logic             is_sub;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_c63;

    // Subtract is a + ~b + 1, so C = 1 means no borrow.
    assign is_sub = (cntrl == ALU_SUB);
    assign add_b  = is_sub ? ~b : b;

    alu64_flag_unit_add64 #(
        .WIDTH (WIDTH)
    ) u_add64 (
        .a    (a),
        .b    (add_b),
        .cin  (is_sub),
        .sum  (add_sum),
        .cout (add_cout),
        .c63  (add_c63)
    );

    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (cntrl)
            ALU_PASS_B: result = b;
            ALU_ADD, ALU_SUB: begin
                result    = add_sum;
                carry_out = add_cout;
                overflow  = add_c63 ^ add_cout;
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

    assign negative = result[WIDTH-1];
    assign zero     = (result == '0);

    logic [NUM_FLAGS-1:0] flags_d;

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_Z] = zero;
        flags_d[FLAG_N] = negative;
        flags_d[FLAG_V] = overflow;
        flags_d[FLAG_C] = carry_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (set_flags) begin
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
        end else if (result_en) begin
            result_q <= result;
        end
    end

endmodule

// File: tb/tb_alu64_flag_unit.sv
// Self-checking bench for alu64_flag_unit: directed corner cases followed by random
// operations compared against an arithmetic reference model.
module tb_alu64_flag_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  cntrl;
    logic        set_flags;
    logic        result_en;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;
    logic [3:0]  flags_q;
    logic [63:0] result_q;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [63:0] m_r;
    logic        m_n, m_z, m_v, m_c;
    logic [3:0]  exp_flags;
    logic [63:0] exp_result_q;

    always #5 clk = ~clk;

    alu64_flag_unit #(
        .WIDTH (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .cntrl     (cntrl),
        .set_flags (set_flags),
        .result_en (result_en),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out),
        .flags_q   (flags_q),
        .result_q  (result_q)
    );

    function automatic void ref_alu(input logic [63:0] x, input logic [63:0] y,
                                    input logic [2:0] op, output logic [63:0] r,
                                    output logic n, output logic z, output logic v,
                                    output logic c);
        logic [64:0] wide;
        r = '0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            3'd0: r = y;
            3'd2: begin
                wide = {1'b0, x} + {1'b0, y};
                r    = wide[63:0];
                c    = wide[64];
                v    = (x[63] == y[63]) && (r[63] != x[63]);
            end
            3'd3: begin
                r = x - y;
                c = (x >= y);
                v = (x[63] != y[63]) && (r[63] != x[63]);
            end
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: r = x ^ y;
            default: r = '0;
        endcase
        n = r[63];
        z = (r == 64'd0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive at negedge, check combinational outputs, take one edge, check the registers.
    task automatic cycle(input logic [63:0] ai, input logic [63:0] bi, input logic [2:0] op,
                         input logic sf, input logic re, input logic rst);
        @(negedge clk);
        a         = ai;
        b         = bi;
        cntrl     = op;
        set_flags = sf;
        result_en = re;
        reset     = rst;
        #1;
        ref_alu(ai, bi, op, m_r, m_n, m_z, m_v, m_c);
        chk("result", result, m_r);
        chk("negative", {63'd0, negative}, {63'd0, m_n});
        chk("zero", {63'd0, zero}, {63'd0, m_z});
        chk("overflow", {63'd0, overflow}, {63'd0, m_v});
        chk("carry_out", {63'd0, carry_out}, {63'd0, m_c});
        if (rst) begin
            exp_flags    = 4'b0000;
            exp_result_q = 64'd0;
        end else begin
            if (sf) exp_flags = {m_c, m_v, m_n, m_z};
            if (re) exp_result_q = m_r;
        end
        @(posedge clk);
        #1;
        chk("flags_q", {60'd0, flags_q}, {60'd0, exp_flags});
        chk("result_q", result_q, exp_result_q);
    endtask

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h7FFF_FFFF_FFFF_FFFF;
            3: v = 64'h8000_0000_0000_0000;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    initial begin
        logic [63:0] ra, rb;
        reset = 1'b0; a = '0; b = '0; cntrl = 3'd0; set_flags = 1'b0; result_en = 1'b0;

        // Reset with both enables high; combinational path stays live.
        cycle(64'd9, 64'd4, 3'b010, 1'b1, 1'b1, 1'b1);
        chk("rst_flags_q", {60'd0, flags_q}, 64'd0);
        chk("rst_result_q", result_q, 64'd0);
        chk("rst_live_result", result, 64'd13);

        cycle(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1, 1'b0, 1'b0);
        chk("addovf_result", result, 64'h8000_0000_0000_0000);
        chk("addovf_nzvc", {60'd0, carry_out, overflow, negative, zero}, 64'b0110);
        chk("addovf_flags_q", {60'd0, flags_q}, 64'b0110);

        cycle(64'd5, 64'd5, 3'b011, 1'b1, 1'b1, 1'b0);
        chk("subeq_result", result, 64'd0);
        chk("subeq_cvnz", {60'd0, carry_out, overflow, negative, zero}, 64'b1001);

        cycle(64'd3, 64'd5, 3'b011, 1'b1, 1'b1, 1'b0);
        chk("sublt_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sublt_cvn", {61'd0, carry_out, overflow, negative}, 64'b001);
        chk("sublt_n_ne_v", {63'd0, flags_q[1] != flags_q[2]}, 64'd1);

        cycle(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("wrap_result", result, 64'd0);
        chk("wrap_cvz", {61'd0, carry_out, overflow, zero}, 64'b101);

        cycle(64'd7, 64'hDEAD_BEEF_0000_0000, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("passb_result", result, 64'hDEAD_BEEF_0000_0000);
        chk("passb_cv", {62'd0, carry_out, overflow}, 64'd0);

        cycle(64'hF0F0, 64'h0FF0, 3'b100, 1'b0, 1'b0, 1'b0);
        chk("and_result", result, 64'h00F0);
        cycle(64'hF0F0, 64'h0FF0, 3'b101, 1'b0, 1'b0, 1'b0);
        chk("or_result", result, 64'hFFF0);
        cycle(64'hF0F0, 64'h0FF0, 3'b110, 1'b0, 1'b0, 1'b0);
        chk("xor_result", result, 64'hFF00);

        cycle(64'hFFFF, 64'h1234, 3'b001, 1'b0, 1'b0, 1'b0);
        chk("rsv1_result", result, 64'd0);
        cycle(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b111, 1'b0, 1'b0, 1'b0);
        chk("rsv7_cv", {62'd0, carry_out, overflow}, 64'd0);

        // Enable hold, then a single result_en pulse.
        for (int i = 0; i < 3; i++) begin
            cycle({$urandom(), $urandom()}, {$urandom(), $urandom()}, 3'b010, 1'b0, 1'b0, 1'b0);
        end
        chk("hold_result_q", result_q, 64'hDEAD_BEEF_0000_0000);
        cycle(64'd10, 64'd20, 3'b010, 1'b0, 1'b1, 1'b0);
        chk("pulse_result_q", result_q, 64'd30);
        cycle(64'd1, 64'd1, 3'b110, 1'b0, 1'b0, 1'b0);
        chk("pulse_hold_q", result_q, 64'd30);

        for (int i = 0; i < 300; i++) begin
            ra = pick_operand();
            rb = ($urandom_range(0, 7) == 0) ? ra : pick_operand();
            cycle(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom()), 1'($urandom()),
                  $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
